// File: rtl/can_pkg.sv
// Shared CAN transmit-scheduler types: priority-key width, scheduler states and key builder.
package can_pkg;

  localparam int unsigned CAN_KEY_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StWaitBus,
    StActive
  } sched_state_e;

  // Key mirrors the on-bus arbitration field order so that a lower key wins arbitration.
  // For a standard frame the 11-bit ID is taken from id[10:0].
  function automatic logic [CAN_KEY_W-1:0] can_build_key(input logic [28:0] id,
                                                         input logic        ide,
                                                         input logic        rtr);
    logic [CAN_KEY_W-1:0] key;
    if (ide) begin
      key = {id[28:18], 1'b1, 1'b1, id[17:0], rtr};
    end else begin
      key = {id[10:0], rtr, 1'b0, 18'd0, 1'b0};
    end
    return key;
  endfunction

endpackage

// File: rtl/can_prio_select.sv
// Combinational argmin over N priority keys masked by a valid vector; ties go to the lower index.
module can_prio_select
  import can_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [CAN_KEY_W*N-1:0]  key_i,
  input  logic [N-1:0]            mask_i,
  output logic                    valid_o,
  output logic [$clog2(N)-1:0]    idx_o
);
  localparam int unsigned IdxW = $clog2(N);

  logic                 found;
  logic [IdxW-1:0]      idx;
  logic [CAN_KEY_W-1:0] best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '1;
    // Strict less-than keeps the earliest (lowest) index on equal keys.
    for (int i = 0; i < int'(N); i++) begin
      if (mask_i[i] && (!found || (key_i[CAN_KEY_W*i +: CAN_KEY_W] < best))) begin
        found = 1'b1;
        best  = key_i[CAN_KEY_W*i +: CAN_KEY_W];
        idx   = IdxW'(i);
      end
    end
  end

  assign valid_o = found;
  assign idx_o   = idx;

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: arbitrates pending mailboxes, sequences the transmitter,
// handles retries, aborts and completion pulses. Define CAN_TXSCHED_ONESHOT_EN for single-shot.
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int unsigned N_MBOX    = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MBOX-1:0]           mb_req,
  input  logic [N_MBOX-1:0]           mb_abort,
  input  logic [CAN_KEY_W*N_MBOX-1:0] mb_key,
  input  logic                        bus_idle,
  input  logic                        tx_done,
  input  logic                        tx_arb_lost,
  input  logic                        tx_error,
  output logic                        tx_start,
  output logic [$clog2(N_MBOX)-1:0]   tx_sel,
  output logic                        busy,
  output logic [N_MBOX-1:0]           pending,
  output logic [N_MBOX-1:0]           mb_ok,
  output logic [N_MBOX-1:0]           mb_fail,
  output logic [N_MBOX-1:0]           mb_aborted
);
  localparam int unsigned IdxW = $clog2(N_MBOX);

  sched_state_e      state_q, state_d;
  logic [N_MBOX-1:0] pending_q, pending_d;
  logic [IdxW-1:0]   tx_sel_q, tx_sel_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              abort_q, abort_d;
  logic [N_MBOX-1:0] ok_q, ok_d, fail_q, fail_d, aborted_q, aborted_d;
`ifndef CAN_TXSCHED_ONESHOT_EN
  logic [N_MBOX-1:0][3:0] cnt_q, cnt_d;
`endif

  logic [N_MBOX-1:0] flight_mask, req_acc, abort_idle;
  logic              abort_now;
  logic              sel_valid;
  logic [IdxW-1:0]   sel_idx;

  // Selection looks at next-cycle pending so same-cycle requests and aborts are honoured.
  can_prio_select #(
    .N (N_MBOX)
  ) u_prio_select (
    .key_i   (mb_key),
    .mask_i  (pending_d),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_comb begin
    flight_mask = '0;
    if (state_q == StActive) flight_mask[tx_sel_q] = 1'b1;

    req_acc    = mb_req & ~mb_abort & ~pending_q;
    abort_idle = mb_abort & pending_q & ~flight_mask;
    abort_now  = abort_q | (|(mb_abort & flight_mask));

    pending_d  = (pending_q | req_acc) & ~abort_idle;
    aborted_d  = abort_idle;
    ok_d       = '0;
    fail_d     = '0;
    state_d    = state_q;
    tx_sel_d   = tx_sel_q;
    tx_start_d = 1'b0;
    abort_d    = abort_now;
`ifndef CAN_TXSCHED_ONESHOT_EN
    cnt_d = cnt_q;
    for (int i = 0; i < int'(N_MBOX); i++) begin
      if (req_acc[i]) cnt_d[i] = '0;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (|pending_q) state_d = StSelect;
      end
      StSelect: begin
        if (sel_valid) begin
          tx_sel_d = sel_idx;
          state_d  = StWaitBus;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitBus: begin
        if ((|req_acc) || (|mb_abort)) begin
          state_d = StSelect;
        end else if (bus_idle) begin
          state_d    = StActive;
          tx_start_d = 1'b1;
        end
      end
      StActive: begin
        if (tx_done) begin
          ok_d[tx_sel_q]      = 1'b1;
          pending_d[tx_sel_q] = 1'b0;
          abort_d             = 1'b0;
          state_d             = StSelect;
        end else if (tx_error || tx_arb_lost) begin
          abort_d = 1'b0;
          state_d = StSelect;
          if (abort_now) begin
            aborted_d[tx_sel_q] = 1'b1;
            pending_d[tx_sel_q] = 1'b0;
          end
`ifdef CAN_TXSCHED_ONESHOT_EN
          else begin
            fail_d[tx_sel_q]    = 1'b1;
            pending_d[tx_sel_q] = 1'b0;
          end
`else
          else if (tx_error) begin
            cnt_d[tx_sel_q] = cnt_q[tx_sel_q] + 4'd1;
            if (cnt_d[tx_sel_q] >= 4'(MAX_RETRY)) begin
              fail_d[tx_sel_q]    = 1'b1;
              pending_d[tx_sel_q] = 1'b0;
            end
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWaitBus) || (state_d == StActive);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      tx_sel_q   <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      ok_q       <= '0;
      fail_q     <= '0;
      aborted_q  <= '0;
`ifndef CAN_TXSCHED_ONESHOT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tx_sel_q   <= tx_sel_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      aborted_q  <= aborted_d;
`ifndef CAN_TXSCHED_ONESHOT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_sel     = tx_sel_q;
  assign busy       = busy_q;
  assign pending    = pending_q;
  assign mb_ok      = ok_q;
  assign mb_fail    = fail_q;
  assign mb_aborted = aborted_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed self-checking bench for can_tx_scheduler (honours CAN_TXSCHED_ONESHOT_EN).
module tb_can_tx_scheduler;
  import can_pkg::*;

  localparam int unsigned N = 4;
`ifdef CAN_TXSCHED_ONESHOT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 3;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   mb_req = '0;
  logic [N-1:0]   mb_abort = '0;
  logic [32*N-1:0] mb_key = '0;
  logic           bus_idle = 1'b0;
  logic           tx_done = 1'b0;
  logic           tx_arb_lost = 1'b0;
  logic           tx_error = 1'b0;
  logic           tx_start;
  logic [1:0]     tx_sel;
  logic           busy;
  logic [N-1:0]   pending, mb_ok, mb_fail, mb_aborted;

  int vectors = 0;
  int errors  = 0;

  can_tx_scheduler #(
    .N_MBOX    (N),
    .MAX_RETRY (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mb_req      (mb_req),
    .mb_abort    (mb_abort),
    .mb_key      (mb_key),
    .bus_idle    (bus_idle),
    .tx_done     (tx_done),
    .tx_arb_lost (tx_arb_lost),
    .tx_error    (tx_error),
    .tx_start    (tx_start),
    .tx_sel      (tx_sel),
    .busy        (busy),
    .pending     (pending),
    .mb_ok       (mb_ok),
    .mb_fail     (mb_fail),
    .mb_aborted  (mb_aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int idx, input logic [31:0] key);
    mb_key[32*idx +: 32] = key;
  endtask

  task automatic wait_start(input int max_cyc, output bit found, output int n);
    found = 1'b0;
    n = 0;
    while (!found && n < max_cyc) begin
      tick();
      n++;
      if (tx_start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({tx_start, busy, tx_sel} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {tx_start, busy, tx_sel});
    end
    vectors++;
    if ({pending, mb_ok, mb_fail, mb_aborted} !== 16'h0) begin
      errors++; $display("FAIL reset_vec: got %h want 0000", {pending, mb_ok, mb_fail, mb_aborted});
    end
  endtask

  task automatic test_single();
    bit found; int n;
    set_key(2, can_build_key(29'h321, 1'b0, 1'b0));
    bus_idle = 1'b1;
    mb_req = 4'b0100; tick(); mb_req = '0;
    vectors++;
    if (pending !== 4'b0100) begin errors++; $display("FAIL single_pend: got %b want 0100", pending); end
    tick();
    vectors++;
    if ({busy, tx_start} !== 2'b00) begin errors++; $display("FAIL single_c2: got %b want 00", {busy, tx_start}); end
    tick();
    vectors++;
    if ({busy, tx_start} !== 2'b10) begin errors++; $display("FAIL single_c3: got %b want 10", {busy, tx_start}); end
    tick();
    vectors++;
    if ({tx_start, tx_sel} !== 3'b110) begin errors++; $display("FAIL single_start: got %b want 110", {tx_start, tx_sel}); end
    tick();
    vectors++;
    if ({tx_start, busy} !== 2'b01) begin errors++; $display("FAIL single_pulse: got %b want 01", {tx_start, busy}); end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    vectors++;
    if ({mb_ok, pending, busy} !== 9'b0100_0000_0) begin
      errors++; $display("FAIL single_done: got %b want 010000000", {mb_ok, pending, busy});
    end
    wait_start(6, found, n);
    vectors++;
    if (found !== 1'b0) begin errors++; $display("FAIL single_nostart: got %b want 0", found); end
  endtask

  task automatic test_priority();
    bit found; int n;
    logic [1:0] exp_order [3];
    exp_order[0] = 2'd1; exp_order[1] = 2'd3; exp_order[2] = 2'd0;
    set_key(0, can_build_key(29'h123, 1'b0, 1'b0));
    set_key(1, can_build_key(29'h100, 1'b0, 1'b0));
    set_key(3, can_build_key(29'h0400_0005, 1'b1, 1'b0));
    bus_idle = 1'b1;
    mb_req = 4'b1011; tick(); mb_req = '0;
    for (int k = 0; k < 3; k++) begin
      wait_start(8, found, n);
      vectors++;
      if (!found || tx_sel !== exp_order[k]) begin
        errors++; $display("FAIL prio_order%0d: got found=%b sel=%0d want sel=%0d", k, found, tx_sel, exp_order[k]);
      end
      if (k > 0) begin
        vectors++;
        if (n !== 2) begin errors++; $display("FAIL prio_b2b%0d: got %0d cycles want 2", k, n); end
      end
      tx_done = 1'b1; tick(); tx_done = 1'b0;
    end
    vectors++;
    if (pending !== 4'b0000) begin errors++; $display("FAIL prio_pend: got %b want 0000", pending); end
    // Equal keys on mailboxes 0 and 2: lower index first.
    set_key(0, can_build_key(29'h055, 1'b0, 1'b0));
    set_key(2, can_build_key(29'h055, 1'b0, 1'b0));
    mb_req = 4'b0101; tick(); mb_req = '0;
    for (int k = 0; k < 2; k++) begin
      wait_start(8, found, n);
      vectors++;
      if (!found || tx_sel !== 2'(2 * k)) begin
        errors++; $display("FAIL prio_tie%0d: got found=%b sel=%0d want sel=%0d", k, found, tx_sel, 2 * k);
      end
      tx_done = 1'b1; tick(); tx_done = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic test_preempt();
    bit found; int n;
    set_key(0, can_build_key(29'h200, 1'b0, 1'b0));
    set_key(1, can_build_key(29'h050, 1'b0, 1'b0));
    bus_idle = 1'b0;
    mb_req = 4'b0001; tick(); mb_req = '0;
    tick(); tick();
    vectors++;
    if ({busy, tx_sel} !== 3'b100) begin errors++; $display("FAIL pre_wait: got %b want 100", {busy, tx_sel}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (tx_start !== 1'b0) begin errors++; $display("FAIL pre_nobus%0d: got %b want 0", k, tx_start); end
    end
    mb_req = 4'b0010; tick(); mb_req = '0;
    tick();
    bus_idle = 1'b1;
    wait_start(6, found, n);
    vectors++;
    if (!found || tx_sel !== 2'd1) begin errors++; $display("FAIL pre_sel: got found=%b sel=%0d want sel=1", found, tx_sel); end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    vectors++;
    if (mb_ok !== 4'b0010) begin errors++; $display("FAIL pre_ok1: got %b want 0010", mb_ok); end
    wait_start(6, found, n);
    vectors++;
    if (!found || tx_sel !== 2'd0) begin errors++; $display("FAIL pre_sel0: got found=%b sel=%0d want sel=0", found, tx_sel); end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    vectors++;
    if (mb_ok !== 4'b0001) begin errors++; $display("FAIL pre_ok0: got %b want 0001", mb_ok); end
    repeat (3) tick();
  endtask

  task automatic test_errors();
    bit found; int n;
    set_key(0, can_build_key(29'h010, 1'b0, 1'b0));
    bus_idle = 1'b1;
    mb_req = 4'b0001; tick(); mb_req = '0;
    for (int a = 1; a <= EXP_ERR; a++) begin
      wait_start(8, found, n);
      vectors++;
      if (!found || tx_sel !== 2'd0) begin errors++; $display("FAIL err_start%0d: got found=%b sel=%0d", a, found, tx_sel); end
      tx_error = 1'b1; tick(); tx_error = 1'b0;
      vectors++;
      if (a < EXP_ERR) begin
        if ({mb_fail, pending} !== 8'b0000_0001) begin
          errors++; $display("FAIL err_retry%0d: got %b want 00000001", a, {mb_fail, pending});
        end
      end else if ({mb_fail, pending} !== 8'b0001_0000) begin
        errors++; $display("FAIL err_fail: got %b want 00010000", {mb_fail, pending});
      end
    end
    wait_start(8, found, n);
    vectors++;
    if (found !== 1'b0) begin errors++; $display("FAIL err_noretry: got %b want 0", found); end
  endtask

  task automatic test_arb_lost();
    bit found; int n;
    set_key(1, can_build_key(29'h077, 1'b0, 1'b0));
    bus_idle = 1'b1;
    mb_req = 4'b0010; tick(); mb_req = '0;
`ifdef CAN_TXSCHED_ONESHOT_EN
    wait_start(8, found, n);
    tx_arb_lost = 1'b1; tick(); tx_arb_lost = 1'b0;
    vectors++;
    if ({mb_fail, pending} !== 8'b0010_0000) begin
      errors++; $display("FAIL arb_oneshot: got %b want 00100000", {mb_fail, pending});
    end
`else
    for (int a = 0; a < 10; a++) begin
      wait_start(8, found, n);
      tx_arb_lost = 1'b1; tick(); tx_arb_lost = 1'b0;
      vectors++;
      if (!found || {mb_fail, pending} !== 8'b0000_0010) begin
        errors++; $display("FAIL arb_lost%0d: got found=%b %b want 00000010", a, found, {mb_fail, pending});
      end
    end
    wait_start(8, found, n);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    vectors++;
    if (!found || mb_ok !== 4'b0010) begin errors++; $display("FAIL arb_done: got found=%b ok=%b want 0010", found, mb_ok); end
`endif
    repeat (3) tick();
  endtask

  task automatic test_abort();
    bit found; int n;
    set_key(2, can_build_key(29'h066, 1'b0, 1'b0));
    bus_idle = 1'b1;
    mb_req = 4'b0100; tick(); mb_req = '0;
    wait_start(8, found, n);
    mb_abort = 4'b0100; tick(); mb_abort = '0;
    vectors++;
    if ({mb_aborted, pending} !== 8'b0000_0100) begin
      errors++; $display("FAIL abort_defer: got %b want 00000100", {mb_aborted, pending});
    end
    tx_error = 1'b1; tick(); tx_error = 1'b0;
    vectors++;
    if ({mb_aborted, mb_fail, pending} !== 12'b0100_0000_0000) begin
      errors++; $display("FAIL abort_err: got %b want 010000000000", {mb_aborted, mb_fail, pending});
    end
    wait_start(8, found, n);
    vectors++;
    if (found !== 1'b0) begin errors++; $display("FAIL abort_noretry: got %b want 0", found); end
    // Abort and request together on an idle mailbox.
    mb_req = 4'b1000; mb_abort = 4'b1000; tick(); mb_req = '0; mb_abort = '0;
    vectors++;
    if ({mb_aborted, pending} !== 8'h00) begin errors++; $display("FAIL abort_reqsame: got %b want 0", {mb_aborted, pending}); end
    tick();
    vectors++;
    if (mb_aborted !== 4'b0000) begin errors++; $display("FAIL abort_reqsame2: got %b want 0000", mb_aborted); end
    // Abort of a pending mailbox waiting for the bus.
    bus_idle = 1'b0;
    mb_req = 4'b0001; tick(); mb_req = '0;
    tick(); tick();
    mb_abort = 4'b0001; tick(); mb_abort = '0;
    vectors++;
    if ({mb_aborted, pending, busy} !== 9'b0001_0000_0) begin
      errors++; $display("FAIL abort_wait: got %b want 000100000", {mb_aborted, pending, busy});
    end
    // Reset mid-frame drops everything silently.
    bus_idle = 1'b1;
    mb_req = 4'b0010; tick(); mb_req = '0;
    wait_start(8, found, n);
    reset = 1'b1; tx_done = 1'b1; tick(); reset = 1'b0; tx_done = 1'b0;
    vectors++;
    if ({tx_start, busy, tx_sel, pending, mb_ok, mb_fail, mb_aborted} !== 20'h0) begin
      errors++; $display("FAIL abort_reset: got %h want 00000",
                         {tx_start, busy, tx_sel, pending, mb_ok, mb_fail, mb_aborted});
    end
    tick();
    vectors++;
    if ({mb_ok, busy} !== 5'b0) begin errors++; $display("FAIL abort_reset2: got %b want 00000", {mb_ok, busy}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_single();
    test_priority();
    test_preempt();
    test_errors();
    test_arb_lost();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
